// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load bus for instr_mem_sync.
// master: fetch stage / loader side; slave: the memory.
interface instr_mem_sync_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               stall;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               fault;
  logic [1:0]         fault_code;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               prog_err;

  modport master (
    output fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
    input  instr, instr_valid, fault, fault_code, prog_err
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
    output instr, instr_valid, fault, fault_code, prog_err
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Byte-addressed instruction memory with a registered 1-cycle fetch port,
// fetch stall, word-write program loading and fault reporting.
// Optional feature macro: IMEM_WRAP_EN (addresses reduced modulo DEPTH_BYTES,
// no range faults, prog_err never set).
module instr_mem_sync #(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 4096,
  parameter int          INSTR_W     = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  instr_mem_sync_if.slave  bus
);
  localparam int BYTES      = INSTR_W / 8;
  localparam int ALIGN      = $clog2(BYTES);
  localparam int DEPTH_LOG2 = $clog2(DEPTH_BYTES);
  localparam int WORDS      = DEPTH_BYTES / BYTES;
  localparam int IDX_W      = DEPTH_LOG2 - ALIGN;

  localparam logic [INSTR_W-1:0] NOP       = INSTR_W'(NOP_WORD);
  localparam logic [ADDR_W:0]    DEPTH_CMP = (ADDR_W+1)'(DEPTH_BYTES);

  // Words stored little-endian: byte at the lowest address is bits [7:0],
  // so a whole-word read is already the assembled instruction.
  logic [INSTR_W-1:0] mem [WORDS];

  logic [IDX_W-1:0]   fetch_idx;
  logic [IDX_W-1:0]   prog_idx;
  logic               fetch_mis;
  logic               fetch_oor;
  logic               prog_oor;
  logic               prog_wr;
  logic [INSTR_W-1:0] rd_word;

  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               fault_q;
  logic [1:0]         code_q;
  logic               prog_err_q;

  // Address bits outside the in-range index are only used for range checks.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.fetch_addr, bus.prog_addr};

  assign fetch_idx = bus.fetch_addr[DEPTH_LOG2-1:ALIGN];
  assign prog_idx  = bus.prog_addr[DEPTH_LOG2-1:ALIGN];
  assign fetch_mis = (bus.fetch_addr[ALIGN-1:0] != '0);

`ifdef IMEM_WRAP_EN
  assign fetch_oor = 1'b0;
  assign prog_oor  = 1'b0;
`else
  assign fetch_oor = ({1'b0, bus.fetch_addr} >= DEPTH_CMP);
  assign prog_oor  = ({1'b0, bus.prog_addr}  >= DEPTH_CMP);
`endif

  assign prog_wr = bus.prog_we && !prog_oor;

  // Read word with write-first forwarding when loading the word being fetched.
  always_comb begin
    rd_word = mem[fetch_idx];
    if (prog_wr && (prog_idx == fetch_idx)) begin
      rd_word = bus.prog_data;
    end
  end

  // Program-load write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && prog_wr) begin
      mem[prog_idx] <= bus.prog_data;
    end
  end

  // Fetch pipeline register and prog_err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= 2'b00;
      prog_err_q <= 1'b0;
    end else begin
      prog_err_q <= bus.prog_we && prog_oor;
      if (!bus.stall) begin
        valid_q <= bus.fetch_req;
        if (bus.fetch_req) begin
          if (fetch_mis) begin
            instr_q <= NOP;
            fault_q <= 1'b1;
            code_q  <= 2'b01;
          end else if (fetch_oor) begin
            instr_q <= NOP;
            fault_q <= 1'b1;
            code_q  <= 2'b10;
          end else begin
            instr_q <= rd_word;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
          end
        end
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.prog_err    = prog_err_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: default 32-bit/4096-byte instance plus a
// 16-bit/256-byte instance. Honours IMEM_WRAP_EN when defined.
module tb_instr_mem_sync;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_mem_sync_if #(.ADDR_W(32), .INSTR_W(32)) ba ();
  instr_mem_sync_if #(.ADDR_W(32), .INSTR_W(16)) bb ();

  instr_mem_sync #(.ADDR_W(32), .DEPTH_BYTES(4096), .INSTR_W(32),
                   .NOP_WORD(32'h0000_0000))
    dut_a (.clk(clk), .rst(rst), .bus(ba.slave));

  instr_mem_sync #(.ADDR_W(32), .DEPTH_BYTES(256), .INSTR_W(16),
                   .NOP_WORD(32'h0000_0000))
    dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ba.fetch_req = 0; ba.fetch_addr = '0; ba.stall = 0;
    ba.prog_we = 0; ba.prog_addr = '0; ba.prog_data = '0;
    bb.fetch_req = 0; bb.fetch_addr = '0; bb.stall = 0;
    bb.prog_we = 0; bb.prog_addr = '0; bb.prog_data = '0;
    tick();
    tick();
    check("rst_instr", 64'(ba.instr), 64'h0);
    check("rst_valid", 64'(ba.instr_valid), 64'h0);
    check("rst_fault", 64'(ba.fault), 64'h0);
    check("rst_code", 64'(ba.fault_code), 64'h0);
    check("rst_prog_err", 64'(ba.prog_err), 64'h0);

    // Program load
    rst = 1'b0;
    ba.prog_we = 1; ba.prog_addr = 32'd0; ba.prog_data = 32'h2001_0028;
    tick();
    check("load0_prog_err", 64'(ba.prog_err), 64'h0);
    ba.prog_addr = 32'd4; ba.prog_data = 32'h2002_0000;
    tick();
    ba.prog_we = 0;

    // Back-to-back fetches
    ba.fetch_req = 1; ba.fetch_addr = 32'd0;
    tick();
    check("f0_instr", 64'(ba.instr), 64'h2001_0028);
    check("f0_valid", 64'(ba.instr_valid), 64'h1);
    check("f0_fault", 64'(ba.fault), 64'h0);
    ba.fetch_addr = 32'd4;
    tick();
    check("f4_instr", 64'(ba.instr), 64'h2002_0000);
    check("f4_valid", 64'(ba.instr_valid), 64'h1);
    check("f4_code", 64'(ba.fault_code), 64'h0);

    // Stall holds outputs and drops the request made during it
    ba.fetch_addr = 32'd0;
    tick();
    check("pre_stall_instr", 64'(ba.instr), 64'h2001_0028);
    ba.stall = 1; ba.fetch_addr = 32'd4;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", 64'(ba.instr), 64'h2001_0028);
      check("stall_valid", 64'(ba.instr_valid), 64'h1);
    end
    ba.stall = 0; ba.fetch_req = 0;
    tick();
    check("post_stall_valid", 64'(ba.instr_valid), 64'h0);
    check("post_stall_hold", 64'(ba.instr), 64'h2001_0028);
    ba.fetch_req = 1; ba.fetch_addr = 32'd4;
    tick();
    check("post_stall_instr", 64'(ba.instr), 64'h2002_0000);
    check("post_stall_valid1", 64'(ba.instr_valid), 64'h1);

    // Misaligned fetch
    ba.fetch_addr = 32'd2;
    tick();
    check("mis_instr", 64'(ba.instr), 64'h0);
    check("mis_fault", 64'(ba.fault), 64'h1);
    check("mis_code", 64'(ba.fault_code), 64'h1);

    // Out-of-range fetch
    ba.fetch_addr = 32'd4096;
    tick();
`ifdef IMEM_WRAP_EN
    check("oor_instr", 64'(ba.instr), 64'h2001_0028);
    check("oor_fault", 64'(ba.fault), 64'h0);
    check("oor_code", 64'(ba.fault_code), 64'h0);
`else
    check("oor_instr", 64'(ba.instr), 64'h0);
    check("oor_fault", 64'(ba.fault), 64'h1);
    check("oor_code", 64'(ba.fault_code), 64'h2);
`endif
    check("oor_valid", 64'(ba.instr_valid), 64'h1);

    // Out-of-range program write
    ba.fetch_req = 0;
    ba.prog_we = 1; ba.prog_addr = 32'd4100; ba.prog_data = 32'h1234_5678;
    tick();
`ifdef IMEM_WRAP_EN
    check("perr_pulse", 64'(ba.prog_err), 64'h0);
`else
    check("perr_pulse", 64'(ba.prog_err), 64'h1);
`endif
    ba.prog_we = 0;
    tick();
    check("perr_end", 64'(ba.prog_err), 64'h0);
    ba.fetch_req = 1; ba.fetch_addr = 32'd4;
    tick();
`ifdef IMEM_WRAP_EN
    check("perr_mem4", 64'(ba.instr), 64'h1234_5678);
`else
    check("perr_mem4", 64'(ba.instr), 64'h2002_0000);
`endif

    // Write-first on same word, same edge
    ba.prog_we = 1; ba.prog_addr = 32'd8; ba.prog_data = 32'hDEAD_BEEF;
    ba.fetch_addr = 32'd8;
    tick();
    ba.prog_we = 0;
    check("wf_instr", 64'(ba.instr), 64'hDEAD_BEEF);
    check("wf_fault", 64'(ba.fault), 64'h0);

    // Reset mid-operation discards the accepted fetch, keeps memory
    ba.fetch_addr = 32'd4;
    tick();
    check("pre_rst_valid", 64'(ba.instr_valid), 64'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(ba.instr_valid), 64'h0);
    check("mid_rst_instr", 64'(ba.instr), 64'h0);
    rst = 1'b0;
    ba.fetch_addr = 32'd0;
    tick();
    check("post_rst_instr", 64'(ba.instr), 64'h2001_0028);
    check("post_rst_valid", 64'(ba.instr_valid), 64'h1);
    ba.fetch_req = 0;

    // 16-bit / 256-byte instance
    bb.prog_we = 1; bb.prog_addr = 32'd6; bb.prog_data = 16'hBEEF;
    tick();
    bb.prog_addr = 32'd0; bb.prog_data = 16'h1234;
    tick();
    bb.prog_we = 0;
    bb.fetch_req = 1; bb.fetch_addr = 32'd6;
    tick();
    check("b_f6_instr", 64'(bb.instr), 64'hBEEF);
    check("b_f6_fault", 64'(bb.fault), 64'h0);
    bb.fetch_addr = 32'd5;
    tick();
    check("b_f5_code", 64'(bb.fault_code), 64'h1);
    check("b_f5_instr", 64'(bb.instr), 64'h0);
    bb.fetch_addr = 32'd256;
    tick();
`ifdef IMEM_WRAP_EN
    check("b_oor_instr", 64'(bb.instr), 64'h1234);
    check("b_oor_code", 64'(bb.fault_code), 64'h0);
`else
    check("b_oor_instr", 64'(bb.instr), 64'h0);
    check("b_oor_code", 64'(bb.fault_code), 64'h2);
`endif
    // Low address bit of a prog write is ignored: @7 lands on word @6
    bb.fetch_req = 0;
    bb.prog_we = 1; bb.prog_addr = 32'd7; bb.prog_data = 16'hCAFE;
    tick();
    bb.prog_we = 0;
    bb.fetch_req = 1; bb.fetch_addr = 32'd6;
    tick();
    check("b_mask_instr", 64'(bb.instr), 64'hCAFE);
    bb.fetch_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
